uart_tx_shift_register: RTL

//  UART transmit serializer. Counterpart of the SoC's UART receive shift register.

---
 rtl/uart_tx_shift_register.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_shift_register.sv
// UART transmit serializer: start bit, DATA_BITS data bits LSB first, optional
// parity, STOP_BITS stop bits, one line bit per baud_clk rising edge.
// Optional feature macro: UART_TX_PARITY_EN inserts a parity bit after the data.
module uart_tx_shift_register #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic       baud_clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       serial_out,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

  // Elaboration-time parameter legality checks
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx_shift_register: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_shift_register: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD > 1) begin : g_bad_parity_odd
    $error("uart_tx_shift_register: PARITY_ODD must be 0 or 1");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic [BYTE_W-1:0] DATA_MASK = 8'hFF >> (BYTE_W - DATA_BITS);
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_e;
`endif

  state_e              state_q, state_d;
  logic [BYTE_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                serial_q, serial_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic                par_q, par_d;
`endif

  // State, datapath and registered output flops; reset forces an idle line
  always_ff @(posedge baud_clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      serial_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      serial_q  <= serial_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  // Next-state and next-output logic; serial_d is the bit shown after this edge
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    serial_d  = serial_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif

    unique case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        busy_d   = 1'b0;
        if (tx_start) begin
          state_d   = START;
          shreg_d   = tx_data;
          bit_cnt_d = '0;
          serial_d  = 1'b0;
          busy_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
          par_d     = (^(tx_data & DATA_MASK)) ^ 1'(PARITY_ODD);
`endif
        end
      end

      START: begin
        state_d   = DATA;
        serial_d  = shreg_q[0];
        shreg_d   = {1'b0, shreg_q[BYTE_W-1:1]};
        bit_cnt_d = CNT_W'(1);
      end

      DATA: begin
        if (bit_cnt_q == LAST_DATA) begin
          bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
          state_d   = PARITY;
          serial_d  = par_q;
`else
          state_d   = STOP;
          serial_d  = 1'b1;
`endif
        end else begin
          serial_d  = shreg_q[0];
          shreg_d   = {1'b0, shreg_q[BYTE_W-1:1]};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        state_d   = STOP;
        serial_d  = 1'b1;
        bit_cnt_d = '0;
      end
`endif

      STOP: begin
        serial_d = 1'b1;
        if (bit_cnt_q == LAST_STOP) begin
          done_d    = 1'b1;
          bit_cnt_d = '0;
          if (tx_start) begin
            state_d  = START;
            shreg_d  = tx_data;
            serial_d = 1'b0;
            busy_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
            par_d    = (^(tx_data & DATA_MASK)) ^ 1'(PARITY_ODD);
`endif
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
        serial_d  = 1'b1;
        busy_d    = 1'b0;
      end
    endcase
  end

  assign serial_out = serial_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;

endmodule
